// File: rtl/pin_entry_collector_pkg.sv
// Shared definitions for the PIN entry collector: key codes, PIN width and
// the one-hot state encoding used by the collector FSM.
package pin_entry_pkg;

    localparam int PASS_W = 8;

    localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;
    localparam logic [3:0] KEY_CLEAR     = 4'hA;
    localparam logic [3:0] KEY_ENTER     = 4'hB;

    typedef enum logic [3:0] {
        IDLE       = 4'b0001,
        WAIT_D1    = 4'b0010,
        WAIT_D2    = 4'b0100,
        WAIT_ENTER = 4'b1000
    } state_t;

endpackage

// File: rtl/pin_entry_collector_if.sv
// Keypad/sensor inputs and PIN presentation outputs of the entry collector.
// The slave side is the collector, the master side is whoever drives keys.
interface pin_entry_if;
    import pin_entry_pkg::*;

    logic              sensorA;
    logic              key_valid;
    logic [3:0]        key_code;
    logic [PASS_W-1:0] pass;
    logic              pass_valid;
    logic              entry_error;
    logic [1:0]        digit_count;

    modport master (
        output sensorA, key_valid, key_code,
        input  pass, pass_valid, entry_error, digit_count
    );

    modport slave (
        input  sensorA, key_valid, key_code,
        output pass, pass_valid, entry_error, digit_count
    );

endinterface

// File: rtl/pin_entry_collector_timer.sv
// Inactivity down-counter: reloads on clear, counts while enabled and flags
// expiry when it reaches zero, reloading itself so the flag lasts one cycle.
module pin_entry_timer #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TIMER_W        = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(TIMEOUT_CYCLES - 1);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= RELOAD;
        end else if (enable) begin
            if (count == '0) begin
                count <= RELOAD;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    // Expiry must not depend on clear: clear is derived from the FSM next state.
    assign expired = enable && (count == '0);

endmodule

// File: rtl/pin_entry_collector.sv
// Collects two keypad digits as packed BCD while a car is at the entry and
// presents them on Enter; malformed or abandoned entries pulse entry_error.
//
// state      | meaning
// -----------+------------------------------------------------------
// IDLE       | no car at entry, keys ignored
// WAIT_D1    | armed, buffer empty, waiting for first digit
// WAIT_D2    | first digit in buffer[7:4], inactivity timer running
// WAIT_ENTER | both digits buffered, waiting for Enter, timer running
module pin_entry_collector
    import pin_entry_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TIMER_W        = $clog2(TIMEOUT_CYCLES)
) (
    input  logic       clk,
    input  logic       rst_n,
    pin_entry_if.slave entry
);

    state_t            state, state_nxt;
    logic [PASS_W-1:0] buffer, buffer_nxt;
    logic [PASS_W-1:0] pass_q, pass_nxt;
    logic              pass_valid_q, pass_valid_nxt;
    logic              entry_error_q, entry_error_nxt;
    logic [1:0]        count_q, count_nxt;

    logic is_digit, is_clear, is_enter, key_accepted;
    logic timer_enable, timer_clear, timer_expired;

    assign is_digit     = entry.key_valid && (entry.key_code <= KEY_MAX_DIGIT);
    assign is_clear     = entry.key_valid && (entry.key_code == KEY_CLEAR);
    assign is_enter     = entry.key_valid && (entry.key_code == KEY_ENTER);
    assign key_accepted = is_digit || is_clear || is_enter;

    assign timer_enable = (state == WAIT_D2) || (state == WAIT_ENTER);
    assign timer_clear  = key_accepted || (state_nxt != state) || !timer_enable;

    pin_entry_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMER_W        (TIMER_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            buffer        <= '0;
            pass_q        <= '0;
            pass_valid_q  <= 1'b0;
            entry_error_q <= 1'b0;
            count_q       <= 2'd0;
        end else begin
            state         <= state_nxt;
            buffer        <= buffer_nxt;
            pass_q        <= pass_nxt;
            pass_valid_q  <= pass_valid_nxt;
            entry_error_q <= entry_error_nxt;
            count_q       <= count_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        buffer_nxt      = buffer;
        pass_nxt        = pass_q;
        count_nxt       = count_q;
        pass_valid_nxt  = 1'b0;
        entry_error_nxt = 1'b0;

        // Car leaving outranks any key or timeout; pass keeps its last value.
        if (state != IDLE && !entry.sensorA) begin
            state_nxt  = IDLE;
            buffer_nxt = '0;
            count_nxt  = 2'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (entry.sensorA) state_nxt = WAIT_D1;
                end
                WAIT_D1: begin
                    if (is_digit) begin
                        buffer_nxt = {entry.key_code, 4'h0};
                        count_nxt  = 2'd1;
                        state_nxt  = WAIT_D2;
                    end else if (is_enter) begin
                        entry_error_nxt = 1'b1;
                    end else if (is_clear) begin
                        buffer_nxt = '0;
                    end
                end
                WAIT_D2: begin
                    if (is_digit) begin
                        buffer_nxt = {buffer[7:4], entry.key_code};
                        count_nxt  = 2'd2;
                        state_nxt  = WAIT_ENTER;
                    end else if (is_enter || is_clear || timer_expired) begin
                        entry_error_nxt = !is_clear;
                        buffer_nxt      = '0;
                        count_nxt       = 2'd0;
                        state_nxt       = WAIT_D1;
                    end
                end
                WAIT_ENTER: begin
                    if (is_enter) begin
                        pass_nxt       = buffer;
                        pass_valid_nxt = 1'b1;
                        buffer_nxt     = '0;
                        count_nxt      = 2'd0;
                        state_nxt      = WAIT_D1;
                    end else if (is_digit) begin
                        entry_error_nxt = 1'b1;
                    end else if (is_clear || timer_expired) begin
                        entry_error_nxt = !is_clear;
                        buffer_nxt      = '0;
                        count_nxt       = 2'd0;
                        state_nxt       = WAIT_D1;
                    end
                end
                default: begin
                    state_nxt  = IDLE;
                    buffer_nxt = '0;
                    count_nxt  = 2'd0;
                end
            endcase
        end
    end

    assign entry.pass        = pass_q;
    assign entry.pass_valid  = pass_valid_q;
    assign entry.entry_error = entry_error_q;
    assign entry.digit_count = count_q;

endmodule

// File: tb/tb_pin_entry_collector.sv
// Bench for pin_entry_collector: directed scenarios plus random keypad traffic,
// every cycle compared against a digit-queue reference model.
module tb_pin_entry_collector;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pin_entry_if bus ();

    pin_entry_collector #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .entry (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: armed flag, queue of buffered digits, age since last key.
    bit         m_armed;
    int         m_digits[$];
    int         m_age;
    logic [7:0] m_pass;
    bit         m_pv;
    bit         m_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_armed = 0;
        m_digits.delete();
        m_age  = 0;
        m_pass = 8'h00;
        m_pv   = 0;
        m_err  = 0;
    endtask

    task automatic model_step(input logic sa, input logic kv, input logic [3:0] kc);
        m_pv  = 0;
        m_err = 0;
        if (!m_armed) begin
            if (sa) m_armed = 1;
        end else if (!sa) begin
            m_armed = 0;
            m_digits.delete();
        end else if (kv && kc <= 4'hB) begin
            m_age = 0;
            if (kc <= 4'h9) begin
                if (m_digits.size() < 2) m_digits.push_back(int'(kc));
                else m_err = 1;
            end else if (kc == 4'hB) begin
                if (m_digits.size() == 2) begin
                    m_pass = 8'(m_digits[0] * 16 + m_digits[1]);
                    m_pv   = 1;
                end else begin
                    m_err = 1;
                end
                m_digits.delete();
            end else begin
                m_digits.delete();
            end
        end else if (m_digits.size() > 0) begin
            m_age++;
            if (m_age == TO) begin
                m_err = 1;
                m_digits.delete();
                m_age = 0;
            end
        end
    endtask

    task automatic compare_outputs();
        check_val("pass", bus.pass, m_pass);
        check_val("pass_valid", bus.pass_valid, m_pv);
        check_val("entry_error", bus.entry_error, m_err);
        check_val("digit_count", bus.digit_count, m_digits.size());
        if (bus.pass_valid || bus.entry_error)
            check_val("pv_err_excl", bus.pass_valid & bus.entry_error, 0);
    endtask

    task automatic step(input logic sa, input logic kv, input logic [3:0] kc);
        bus.sensorA   = sa;
        bus.key_valid = kv;
        bus.key_code  = kc;
        @(posedge clk);
        model_step(sa, kv, kc);
        #1;
        compare_outputs();
    endtask

    task automatic key(input logic [3:0] kc);
        step(1'b1, 1'b1, kc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'h0);
    endtask

    initial begin
        bit         quiet;
        int         x;
        logic       sa;
        logic [3:0] kc;

        bus.sensorA   = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        model_reset();
        #1;
        compare_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 2,6,Enter
        step(1'b1, 1'b0, 4'h0);
        key(4'h2);
        key(4'h6);
        key(4'hB);
        check_val("pass_26", bus.pass, 8'h26);
        idle(1);

        // Enter after one digit, then 9,7,Enter
        key(4'h2);
        key(4'hB);
        key(4'h9);
        key(4'h7);
        key(4'hB);
        check_val("pass_97", bus.pass, 8'h97);

        // Timeout after one digit, then a digit just before expiry
        key(4'h5);
        idle(TO);
        check_val("timeout_err", bus.entry_error, 1'b1);
        key(4'h5);
        idle(TO - 2);
        key(4'h3);
        check_val("no_timeout", bus.entry_error, 1'b0);
        key(4'hB);
        check_val("pass_53", bus.pass, 8'h53);

        // Clear and reserved keys
        key(4'h1); key(4'hE); key(4'h3); key(4'hA); key(4'hE);
        key(4'h4); key(4'h2); key(4'hE); key(4'hB);
        check_val("pass_42", bus.pass, 8'h42);

        // Car leaves together with Enter
        key(4'h2);
        key(4'h6);
        step(1'b0, 1'b1, 4'hB);
        check_val("leave_no_pv", bus.pass_valid, 1'b0);
        step(1'b0, 1'b1, 4'h3);
        step(1'b0, 1'b1, 4'hB);
        check_val("pass_hold", bus.pass, 8'h42);

        // Async reset mid-entry
        step(1'b1, 1'b0, 4'h0);
        key(4'h7);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        bus.sensorA   = 1'b0;
        bus.key_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 4'h5);
        step(1'b0, 1'b1, 4'hB);
        step(1'b1, 1'b1, 4'h5);
        check_val("idle_ignores", bus.digit_count, 2'd0);

        // Random traffic
        quiet = 0;
        sa    = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if (c % 60 == 0) quiet = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) < 2) sa = ~sa;
            x = $urandom_range(0, 19);
            if (x < 10)      kc = 4'(x);
            else if (x < 13) kc = 4'hB;
            else if (x < 15) kc = 4'hA;
            else             kc = 4'($urandom_range(12, 15));
            if (quiet) step(sa, ($urandom_range(0, 39) == 0), kc);
            else       step(sa, ($urandom_range(0, 9) < 4), kc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pin_entry_collector.md
Name: pin_entry_collector

Overview:
- Upstream stage of the parking gate controller. Turns keypad strobes into the 8-bit `pass` value that the gate controller compares against its stored PIN.
- Arms only while a car is at the entry (`sensorA`). Assembles two decimal digits as packed BCD, first digit in the high nibble.
- Presents the code with a one-cycle `pass_valid` on Enter.
- Flags malformed or abandoned entries on `entry_error`.

Parameters:
- TIMEOUT_CYCLES, 1000: inactivity limit, counted in clocks, after the first digit is accepted. Legal range is 2 or more.
- TIMER_W, $clog2(TIMEOUT_CYCLES): width of the inactivity counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sensorA  in  1  car present at entry. Synchronous and debounced upstream.
- key_valid  in  1  one-cycle strobe: `key_code` is valid this cycle.
- key_code  in  4  0x0-0x9 digit, 0xA Clear, 0xB Enter, 0xC-0xF reserved.
- pass  out  8  packed BCD PIN. Registered; holds its value between presentations.
- pass_valid  out  1  registered one-cycle pulse: `pass` is freshly presented.
- entry_error  out  1  registered one-cycle pulse: entry was rejected or timed out.
- digit_count  out  2  digits currently buffered (0-2), for the display.

Behaviour:
- Reset is asynchronous and active-low, on `rst_n`. Clock is `clk`.
- Reset values: state IDLE; `pass`=8'h00; `pass_valid`=0; `entry_error`=0; `digit_count`=0; timer=0; digit buffer=0.
- All outputs are registered. A key sampled at edge N produces its response in the cycle following edge N (latency 1).
- State machine, one-hot encoded:
  - IDLE: keys ignored. `sensorA`=1 -> WAIT_D1.
  - WAIT_D1: digit -> buffer[7:4]=digit, count=1, timer cleared, go to WAIT_D2. Enter -> `entry_error` pulse, stay. Clear -> stay, buffer cleared.
  - WAIT_D2: digit -> buffer[3:0]=digit, count=2, timer cleared, go to WAIT_ENTER. Enter -> `entry_error` pulse, buffer and count cleared, go to WAIT_D1. Clear -> buffer and count cleared, go to WAIT_D1.
  - WAIT_ENTER: Enter -> `pass`<=buffer, `pass_valid` pulse, buffer and count cleared, go to WAIT_D1 so a retry is possible while the car remains. Digit -> ignored, `entry_error` pulse, buffer kept, timer cleared. Clear -> buffer and count cleared, go to WAIT_D1.
- `sensorA`=0 in any non-IDLE state -> IDLE. Buffer, count and timer are cleared; no error pulse; `pass` keeps its last value.
- Reserved key codes (0xC-0xF) are ignored in every state. They do not clear the timer.
- Inactivity timer:
  - Counts only in WAIT_D2 and WAIT_ENTER; cleared on every accepted key and on every state change.
  - If no key is accepted for TIMEOUT_CYCLES edges after the last accepted key, the buffer is cleared, state goes to WAIT_D1, and `entry_error` pulses.
  - The error is registered at edge lastkey+TIMEOUT_CYCLES.
- Simultaneous events, in priority order (highest first):
  1. `sensorA` falling: wins over any key and over timeout.
  2. An accepted key in the timeout cycle: the key wins and the timer clears.
- `pass_valid` and `entry_error` are never asserted in the same cycle.
- Reset asserted mid-entry returns to IDLE immediately, asynchronously, with the reset values above.
- Digits are not range-checked beyond the key code: 0x0-0x9 only reach the buffer. `pass` is always valid BCD or 8'h00.

Decomposition:
- Shared package `pin_entry_pkg` holds:
  - key code constants KEY_CLEAR=4'hA, KEY_ENTER=4'hB;
  - PASS_W=8;
  - the one-hot state constants IDLE, WAIT_D1, WAIT_D2, WAIT_ENTER.
- One sub-module, `pin_entry_timer`:
  - parameterised by TIMEOUT_CYCLES;
  - inputs: clear, enable;
  - output: a one-cycle `expired` pulse.
- The FSM, digit buffer and output registers stay in the top module.

Test Plan:
- Reset then `sensorA`=1, keys 2,6,Enter on consecutive cycles -> `pass`=8'h26 and `pass_valid` high exactly one cycle, one cycle after the Enter edge; `digit_count` sequence 1,2,0.
- `sensorA`=1, keys 2,Enter -> `entry_error` one cycle, `pass` unchanged at 8'h00, `digit_count`=0. Then 9,7,Enter -> `pass`=8'h97 with `pass_valid`.
- TIMEOUT_CYCLES=8, key 5, then idle -> `entry_error` exactly 8 edges after the key edge, `digit_count`=0. Repeat with a second digit at edge 7 -> no error.
- Keys 1,3,Clear,4,2,Enter -> `pass`=8'h42; key 0xE interleaved anywhere -> no effect.
- Keys 2,6, then `sensorA`=0 in the same cycle as Enter -> no `pass_valid`, state IDLE, `pass` holds its prior value; keys with `sensorA`=0 are ignored.
- `rst_n` pulsed low mid-entry (after one digit), asynchronous to `clk` -> all outputs zero immediately; after release, IDLE with keys ignored until `sensorA`=1.
